// File: rtl/countdown_timer.sv
// Preset down-counter with prescaled tick, pause/resume and expiry flag.
// Optional COUNTDOWN_TIMER_AUTO_RELOAD_EN: reload the latched preset on expiry and keep running.
module countdown_timer #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX        = 99,
    parameter int TICK_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  start,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  running,
    output logic                  expired,
    output logic                  done
);
    localparam int                  PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]       TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DATA_WIDTH-1:0] MAXV    = DATA_WIDTH'(MAX);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t                  state;
    logic [PW-1:0]           presc;
    logic [DATA_WIDTH-1:0]   preset;
    logic [DATA_WIDTH-1:0]   clamped;

    assign clamped = (load_value > MAXV) ? MAXV : load_value;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            presc   <= '0;
            preset  <= '0;
            running <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop && state == RUN) begin
                // Pause freezes count and prescaler, even on a terminal tick.
                state   <= PAUSED;
                running <= 1'b0;
            end else if (load && state != RUN) begin
                count   <= clamped;
                preset  <= clamped;
                state   <= IDLE;
                presc   <= '0;
                running <= 1'b0;
                expired <= 1'b0;
            end else if (start && !stop && (state == IDLE || state == PAUSED)
                         && count != '0) begin
                state   <= RUN;
                running <= 1'b1;
                // Resume keeps the partial tick; a fresh start does not.
                if (state == IDLE)
                    presc <= '0;
            end else if (state == RUN) begin
                if (presc == TICK_LAST) begin
                    presc <= '0;
                    if (count == DATA_WIDTH'(1)) begin
                        done <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                        if (preset != '0) begin
                            count <= preset;
                        end else begin
                            count   <= '0;
                            state   <= EXPIRED;
                            running <= 1'b0;
                            expired <= 1'b1;
                        end
`else
                        count   <= '0;
                        state   <= EXPIRED;
                        running <= 1'b0;
                        expired <= 1'b1;
`endif
                    end else if (count != '0) begin
                        count <= count - 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: instance a runs with TICK_DIV=1, instance b with TICK_DIV=4.
module tb_countdown_timer;
    logic        clk = 1'b0;
    logic        ra, la, sa, pa;
    logic        rb, lb, sb, pb;
    logic [15:0] va, vb;
    logic [15:0] ca, cb;
    logic        runa, expa, dna, runb, expb, dnb;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    countdown_timer #(.DATA_WIDTH(16), .MAX(99), .TICK_DIV(1)) u_a (
        .clk(clk), .reset(ra), .load(la), .load_value(va), .start(sa), .stop(pa),
        .count(ca), .running(runa), .expired(expa), .done(dna));

    countdown_timer #(.DATA_WIDTH(16), .MAX(99), .TICK_DIV(4)) u_b (
        .clk(clk), .reset(rb), .load(lb), .load_value(vb), .start(sb), .stop(pb),
        .count(cb), .running(runb), .expired(expb), .done(dnb));

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check count/running/expired/done of instance a in one call.
    task automatic chka(input string tag, input int c, input int r, input int e, input int d);
        chk({tag, ".count"}, int'(ca), c);
        chk({tag, ".running"}, int'(runa), r);
        chk({tag, ".expired"}, int'(expa), e);
        chk({tag, ".done"}, int'(dna), d);
    endtask

    initial begin
        ra = 1'b0; la = 1'b0; sa = 1'b0; pa = 1'b0; va = '0;
        rb = 1'b0; lb = 1'b0; sb = 1'b0; pb = 1'b0; vb = '0;
        #20;
        chka("rst", 0, 0, 0, 0);
        @(negedge clk);
        ra = 1'b1; rb = 1'b1;
        step();

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        la = 1'b1; va = 16'd3; step(); la = 1'b0;
        chka("ar_load", 3, 0, 0, 0);
        sa = 1'b1; step(); sa = 1'b0;
        chka("ar_start", 3, 1, 0, 0);
        step(); chka("ar_2", 2, 1, 0, 0);
        step(); chka("ar_1", 1, 1, 0, 0);
        step(); chka("ar_reload", 3, 1, 0, 1);
        step(); chka("ar_2b", 2, 1, 0, 0);
        step(); chka("ar_1b", 1, 1, 0, 0);
        step(); chka("ar_reload2", 3, 1, 0, 1);
`else
        // Basic 5..0 countdown.
        la = 1'b1; va = 16'd5; step(); la = 1'b0;
        chka("load5", 5, 0, 0, 0);
        sa = 1'b1; step(); sa = 1'b0;
        chka("start", 5, 1, 0, 0);
        for (int i = 4; i >= 1; i--) begin
            step(); chka("dec", i, 1, 0, 0);
        end
        step(); chka("zero", 0, 0, 1, 1);
        step(); chka("after", 0, 0, 1, 0);
        sa = 1'b1; step(); sa = 1'b0;
        chka("start_exp", 0, 0, 1, 0);

        // Clamp and load clearing expiry.
        la = 1'b1; va = 16'd150; step();
        chka("clamp150", 99, 0, 0, 0);
        va = 16'd99; step(); la = 1'b0;
        chka("clamp99", 99, 0, 0, 0);

        // start+stop together in IDLE.
        sa = 1'b1; pa = 1'b1; step(); sa = 1'b0; pa = 1'b0;
        chka("ss_idle", 99, 0, 0, 0);

        // load during RUN is ignored.
        sa = 1'b1; step(); sa = 1'b0;
        chka("run99", 99, 1, 0, 0);
        la = 1'b1; va = 16'd5; step(); la = 1'b0;
        chka("load_in_run", 98, 1, 0, 0);

        // stop on a terminal tick: no decrement, no done.
        pa = 1'b1; step(); pa = 1'b0;
        chka("pause", 98, 0, 0, 0);
        la = 1'b1; va = 16'd2; step(); la = 1'b0;
        chka("load2", 2, 0, 0, 0);
        sa = 1'b1; step(); sa = 1'b0;
        step(); chka("two_to_one", 1, 1, 0, 0);
        pa = 1'b1; step(); pa = 1'b0;
        chka("stop_term", 1, 0, 0, 0);
        sa = 1'b1; step(); sa = 1'b0;
        chka("resume", 1, 1, 0, 0);
        step(); chka("expire2", 0, 0, 1, 1);

        // Asynchronous reset mid-run at 37.
        la = 1'b1; va = 16'd37; step(); la = 1'b0;
        sa = 1'b1; step(); sa = 1'b0;
        chka("run37", 37, 1, 0, 0);
        #2 ra = 1'b0;
        #1 chka("async_rst", 0, 0, 0, 0);
        @(negedge clk) ra = 1'b1;
`endif

        // Prescaled countdown with pause/resume, TICK_DIV=4.
        lb = 1'b1; vb = 16'd3; step(); lb = 1'b0;
        chk("b_load", int'(cb), 3);
        sb = 1'b1; step(); sb = 1'b0;
        chk("b_start_run", int'(runb), 1);
        for (int e = 1; e <= 3; e++) begin
            step(); chk("b_hold3", int'(cb), 3);
        end
        step(); chk("b_e4", int'(cb), 2);
        step(); chk("b_e5", int'(cb), 2);
        step(); chk("b_e6", int'(cb), 2);
        pb = 1'b1; step(); pb = 1'b0;
        chk("b_stop_cnt", int'(cb), 2);
        chk("b_stop_run", int'(runb), 0);
        step(); step(); chk("b_frozen", int'(cb), 2);
        sb = 1'b1; step(); sb = 1'b0;
        chk("b_resume_run", int'(runb), 1);
        chk("b_resume_cnt", int'(cb), 2);
        step(); chk("b_r1", int'(cb), 2);
        step(); chk("b_r2", int'(cb), 1);
        chk("b_done", int'(dnb), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting companion to the stopwatch counter: loads a preset, counts down to zero on start, halts on stop, and flags expiry.
- Sits beside the stopwatch counter in the timer subsystem and shares its start/stop control convention.
- Decrement rate is set by an internal prescaler, so one block serves both fast simulation and real-time use.

Parameters:
- DATA_WIDTH, 16, width of load_value and count.
- MAX, 99, largest loadable preset; larger load values are clamped to MAX.
- TICK_DIV, 1, clocks per decrement (>=1); prescaler width is clog2(TICK_DIV), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  load preset (level, sampled each edge).
- load_value  input  DATA_WIDTH  preset value.
- start  input  1  begin or resume countdown.
- stop  input  1  pause countdown.
- count  output  DATA_WIDTH  current remaining count (registered).
- running  output  1  high while in RUN.
- expired  output  1  high while in EXPIRED.
- done  output  1  one-cycle pulse on reaching zero.

Behaviour:
- Reset (reset=0, asynchronous): count=0, state=IDLE, prescaler=0, running=0, expired=0, done=0. Release is synchronous to the next clk edge.
- States: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered and decoded from state; done is a registered pulse.
- Per-edge priority: stop > load > start.
- load, when state != RUN:
  - count <= (load_value > MAX) ? MAX : load_value.
  - state <= IDLE, prescaler <= 0, latched preset <= clamped value.
  - Clears expired.
- load while in RUN is ignored.
- start in IDLE or PAUSED with count != 0: state <= RUN, running=1 from the next cycle.
  - From IDLE, prescaler is cleared.
  - From PAUSED, prescaler is held, so a resume continues the partial tick.
- start with count == 0, start while in RUN, and start while in EXPIRED are all ignored.
- RUN: prescaler increments each edge.
  - When it equals TICK_DIV-1, it wraps to 0 and count decrements on that same edge.
  - First decrement occurs TICK_DIV edges after the edge that entered RUN.
- Expiry: the decrement that takes count 1 -> 0 also sets state <= EXPIRED, running <= 0, expired <= 1, done <= 1 for exactly one cycle.
- stop in RUN: state <= PAUSED; count and prescaler frozen.
  - stop on the same edge as a terminal tick wins: no decrement, no done.
  - stop outside RUN has no effect.
- start and stop on the same edge: stop wins (RUN -> PAUSED; IDLE/PAUSED unchanged).
- EXPIRED is left only by load or reset. count remains 0.
- No underflow: count never wraps below 0.
- Reset mid-countdown returns everything to reset values immediately and clears the latched preset to 0.

Optional Feature:
- Macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN.
- Defined: on the expiry edge, count <= latched preset, state remains RUN, running stays 1, prescaler wraps to 0, and done still pulses for one cycle. expired is never asserted. If the latched preset is 0, behaviour matches the macro-undefined case.
- Undefined: expiry enters EXPIRED as described in Behaviour.

Test Plan:
- TICK_DIV=1; reset low 20 ns, release; load=1 with load_value=5 for one cycle; start pulse -> running=1, count sequence 5,4,3,2,1,0 on consecutive edges; done high exactly one cycle coincident with count=0; expired=1 afterwards; a further start leaves count=0.
- load_value=150 with MAX=99 -> count=99; load_value=99 -> count=99.
- TICK_DIV=4; load 3, start -> count decrements every 4 edges (3 at edges 1-3, 2 at edge 4, ...); stop asserted after 6 edges -> count=2, frozen; start -> next decrement after the remaining 2 edges.
- start and stop asserted on the same edge in IDLE -> stays IDLE, running=0. During RUN, stop on a terminal-tick edge -> no decrement, no done. load during RUN -> ignored.
- Reset asserted asynchronously mid-RUN at count=37 -> count=0, running=0, done=0 immediately, without waiting for a clock edge.
- With COUNTDOWN_TIMER_AUTO_RELOAD_EN, load 3 and start -> count 3,2,1,0->3,2,... with done pulsing every 3 decrements; running stays 1 and expired stays 0.
